// File: rtl/line_loader.sv
// -----------------------------------------------------------------------------
// line_loader
//
// Program loader for the line memory. Accepts a byte stream over a
// valid/ready handshake, packs bytes big-endian into LINE_WIDTH-bit lines and
// writes each completed line to the line memory write port at consecutive
// addresses starting at 0. While a program is loading, busy holds the
// sequencer off.
//
// Ports
//   clk           : single clock, rising edge
//   rst           : synchronous active-high reset
//   start         : one-cycle pulse that opens a load session (from idle/error)
//   s_valid       : stream byte present
//   s_data        : stream byte
//   s_last        : final byte of the program (qualified by s_valid)
//   s_ready       : loader accepts a byte this cycle
//   wr_en         : line memory write strobe
//   wr_addr       : line memory write address (held between writes)
//   wr_line       : line memory write data (held between writes)
//   busy          : load in progress
//   done          : one-cycle pulse after a successful load
//   err           : sticky load error (partial line or memory overflow)
//   lines_loaded  : lines written in the current or last session
// -----------------------------------------------------------------------------
module line_loader #(
   parameter int unsigned IP_WIDTH   = 8,
   parameter int unsigned LINE_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [7:0]            s_data,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic                  wr_en,
   output logic [IP_WIDTH-1:0]   wr_addr,
   output logic [LINE_WIDTH-1:0] wr_line,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [IP_WIDTH:0]     lines_loaded
);

   localparam int unsigned Bytes = LINE_WIDTH / 8;
   // Keep the byte counter at least one bit wide for single-byte lines.
   localparam int unsigned CntW  = (Bytes > 1) ? $clog2(Bytes) : 1;

   localparam logic [CntW-1:0]     LastByte = CntW'(Bytes - 1);
   localparam logic [IP_WIDTH-1:0] AddrMax  = '1;

   typedef enum logic [2:0] {
      StIdle,
      StAssemble,
      StWrite,
      StDone,
      StError
   } state_e;

   state_e                state_q, state_d;
   logic [IP_WIDTH-1:0]   addr_q, addr_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [LINE_WIDTH-1:0] sr_q, sr_d;
   logic                  last_q, last_d;
   logic [IP_WIDTH:0]     lines_q, lines_d;
   logic [IP_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [LINE_WIDTH-1:0] wr_line_q, wr_line_d;

   logic                  xfer;
   logic                  line_full;
   logic                  session_start;
   logic [LINE_WIDTH-1:0] sr_shift;

   // s_ready is a pure decode of state, so a transfer needs only s_valid here.
   assign xfer          = (state_q == StAssemble) && s_valid;
   assign line_full     = (cnt_q == LastByte);
   // start only opens a session when not busy.
   assign session_start = start && ((state_q == StIdle) || (state_q == StError));
   // First byte of a line ends up in the MSBs after Bytes shifts.
   assign sr_shift      = (sr_q << 8) | LINE_WIDTH'(s_data);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StAssemble;
            end
         end
         StAssemble: begin
            if (xfer) begin
               if (line_full) begin
                  state_d = StWrite;
               end else if (s_last) begin
                  // Program ended mid-line: the partial line is dropped.
                  state_d = StError;
               end
            end
         end
         StWrite: begin
            if (last_q) begin
               state_d = StDone;
            end else if (addr_q == AddrMax) begin
               // Memory full but the stream has more data.
               state_d = StError;
            end else begin
               state_d = StAssemble;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         StError: begin
            if (start) begin
               state_d = StAssemble;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '0;
         cnt_q     <= '0;
         sr_q      <= '0;
         last_q    <= 1'b0;
         lines_q   <= '0;
         wr_addr_q <= '0;
         wr_line_q <= '0;
      end else begin
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         sr_q      <= sr_d;
         last_q    <= last_d;
         lines_q   <= lines_d;
         wr_addr_q <= wr_addr_d;
         wr_line_q <= wr_line_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      sr_d      = sr_q;
      last_d    = last_q;
      lines_d   = lines_q;
      wr_addr_d = wr_addr_q;
      wr_line_d = wr_line_q;

      if (session_start) begin
         addr_d  = '0;
         cnt_d   = '0;
         lines_d = '0;
         last_d  = 1'b0;
      end

      if (xfer) begin
         sr_d = sr_shift;
         if (line_full) begin
            cnt_d  = '0;
            last_d = s_last;
            // Write port registers are loaded here so they present the line
            // during the WRITE cycle and hold it afterwards.
            wr_addr_d = addr_q;
            wr_line_d = sr_shift;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end

      if (state_q == StWrite) begin
         lines_d = lines_q + (IP_WIDTH + 1)'(1);
         if (!last_q && (addr_q != AddrMax)) begin
            addr_d = addr_q + IP_WIDTH'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: decoded from state and registers only
   // ---------------------------------------------------------------------------
   always_comb begin
      s_ready = 1'b0;
      wr_en   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      unique case (state_q)
         StIdle: begin
         end
         StAssemble: begin
            s_ready = 1'b1;
            busy    = 1'b1;
         end
         StWrite: begin
            wr_en = 1'b1;
            busy  = 1'b1;
         end
         StDone: begin
            done = 1'b1;
            busy = 1'b1;
         end
         StError: begin
            err = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign wr_addr      = wr_addr_q;
   assign wr_line      = wr_line_q;
   assign lines_loaded = lines_q;

endmodule

// File: doc/line_loader.md
# line_loader

Program loader for the line memory: the write-side counterpart to the core's line fetch path. It accepts a byte stream over a valid/ready handshake and assembles big-endian `LINE_WIDTH`-bit lines. It writes each line to the line memory write port at consecutive `ip` addresses starting at 0. `busy` holds the sequencer off while a program is being loaded.

## Interface
Parameters:
- `IP_WIDTH`, 8: line address width; capacity is 2^IP_WIDTH lines.
- `LINE_WIDTH`, 32: line width in bits; must be a multiple of 8. BYTES = LINE_WIDTH/8.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a load session.
- `s_valid` in 1: a stream byte is present.
- `s_data` in 8: stream byte.
- `s_last` in 1: the byte is the final byte of the program; qualified by `s_valid`.
- `s_ready` out 1: the loader accepts a byte this cycle.
- `wr_en` out 1: line memory write strobe.
- `wr_addr` out IP_WIDTH: line memory write address.
- `wr_line` out LINE_WIDTH: line memory write data.
- `busy` out 1: a load is in progress; the CPU must not run.
- `done` out 1: one-cycle pulse marking a successful load.
- `err` out 1: sticky load error.
- `lines_loaded` out IP_WIDTH+1: number of lines written in the current or last session.

## Operation
- States: IDLE, ASSEMBLE, WRITE, DONE, ERROR.
- A byte transfer occurs when `s_valid && s_ready`.
- **IDLE**
  - `s_ready`=0.
  - On `start`: clear the address, byte counter, `lines_loaded`, and the latched-last flag, then go to ASSEMBLE.
- **ASSEMBLE**
  - `s_ready`=1.
  - On each transfer: the shift register takes {sr[LINE_WIDTH-9:0], s_data}, so the first byte lands in the MSB. The byte counter increments.
  - On the transfer that completes byte BYTES-1: latch `s_last`, clear the byte counter, go to WRITE.
  - If a transfer has `s_last`=1 before byte BYTES-1: go to ERROR. This is a partial line, and it is never written.
- **WRITE** (exactly one cycle)
  - `s_ready`=0.
  - Drive `wr_en`=1, `wr_addr`=address, `wr_line`=shift register.
  - Increment `lines_loaded`.
  - If last was latched: go to DONE.
  - Else if the address equals 2^IP_WIDTH-1: go to ERROR, because memory is full and more data is pending.
  - Else increment the address and return to ASSEMBLE.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- **ERROR**
  - `err`=1, `s_ready`=0.
  - Stays in ERROR until `rst` or `start`.
  - `start` in ERROR clears `err` and begins a new session exactly as it does from IDLE.
- `busy`=1 in ASSEMBLE, WRITE and DONE; `busy`=0 in IDLE and ERROR.
- `start` is ignored while `busy`=1.
- `wr_addr`/`wr_line` hold their last values when `wr_en`=0. Consumers use them only when `wr_en`=1.
- A session is never cut short by lack of data; the loader waits indefinitely in ASSEMBLE.
- `lines_loaded` saturates naturally at 2^IP_WIDTH; its width is sized for that value.

## Timing
- Reset: state IDLE. All outputs 0, including `s_ready`, `wr_en`, `wr_addr`, `wr_line`, `busy`, `done`, `err` and `lines_loaded`. The internal shift register and counters are also 0.
- `rst` mid-session aborts immediately with no further write. Lines already written stay in line memory.
- `start` sampled at edge N: state is ASSEMBLE from N+1, and `s_ready` and `busy` are high from the cycle after N.
- At full throughput each line takes BYTES transfer cycles plus 1 WRITE cycle (5 cycles for 32-bit lines).
- `wr_en` is high in the cycle immediately after the final byte of a line is accepted.
- `done` is high in the cycle after the last WRITE. `busy` drops in the cycle after `done`.
- `err` rises in the cycle after the offending transfer, or in the cycle after the overflowing WRITE.
- All outputs are registered or decoded from state and registers only. There are no combinational paths from `s_valid`/`s_data` to any output.

## Test plan
- Reset: hold `rst` 2 cycles, with `s_valid`=1 and `start` pulsed -> all outputs 0 and no write occurs.
- Single line: `start`, then bytes DE, AD, BE, EF with `s_last` on EF -> one `wr_en` cycle with `wr_addr`=0 and `wr_line`=32'hDEADBEEF, then `done` next cycle, `lines_loaded`=1, `busy` low after.
- Three lines with random `s_valid` gaps -> writes to addresses 0, 1, 2 with the correct data. `s_ready` is low in every WRITE cycle and no byte is lost or duplicated. `lines_loaded`=3.
- Partial line: 6 bytes with `s_last` on byte 6 -> exactly one write (addr 0), then `err`=1, `busy`=0, `lines_loaded`=1. A following `start` clears `err`, and a clean 4-byte load succeeds.
- Overflow (`IP_WIDTH`=2): 20 bytes with no `s_last` -> writes to addresses 0-3, `err`=1 after the 4th write, `s_ready`=0, `lines_loaded`=4.
- Interference: `start` pulsed mid-session is ignored with no address reset. `rst` asserted between bytes 2 and 3 of line 1 -> no write for line 1, all outputs 0, and a subsequent load starts at address 0.
